// File: rtl/ysyx_23060201_pkg.sv
// Shared constants and helpers for the NPC register file.
// Default widths, zero-register index, packed-port slice extraction.
package ysyx_23060201_pkg;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int ZERO_IDX = 0;
  localparam int VEC_MAX  = 1024;

  typedef logic [VEC_MAX-1:0] vec_t;

  // Caller zero-extends into vec_t and truncates the result.
  function automatic vec_t get_slice(
    input vec_t        vec,
    input int unsigned i,
    input int unsigned w
  );
    vec_t mask;
    mask = (vec_t'(1) << w) - vec_t'(1);
    return (vec >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/ysyx_23060201_scoreboard.sv
// Busy scoreboard: one busy bit per register plus population count.
// Ports: clk, rst (async low), alloc_en/addr, clr_en/addr, busy, busy_cnt.
module ysyx_23060201_scoreboard
  import ysyx_23060201_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_AW,
  localparam int NREG = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [NREG-1:0]       busy,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  logic [NREG-1:0]     busy_q, busy_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                alloc_v, clr_v, same;
  logic                inc, dec;

  assign alloc_v = alloc_en && (alloc_addr != ADDR_WIDTH'(ZERO_IDX));
  assign clr_v   = clr_en && (clr_addr != ADDR_WIDTH'(ZERO_IDX));
  assign same    = alloc_v && clr_v && (alloc_addr == clr_addr);

  always_comb begin
    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (clr_v) begin
      busy_d[clr_addr] = 1'b0;
      // A same-index alloc re-sets the bit, so no net drop.
      dec = busy_q[clr_addr] && !same;
    end
    if (alloc_v) begin
      busy_d[alloc_addr] = 1'b1;
      inc = !busy_q[alloc_addr];
    end
    cnt_d = cnt_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/ysyx_23060201_regfile.sv
// GPR file: NREAD comb read ports, one write port, busy scoreboard.
// Ports: ren/raddr/rdata/rbusy, stall, wen/waddr/wdata, alloc, busy_cnt.
module ysyx_23060201_regfile
  import ysyx_23060201_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_AW,
  parameter int DATA_WIDTH = DEF_DW,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1,
  localparam int NREG = 1 << ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD-1:0]            ren,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  output logic                        stall,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        alloc_en,
  input  logic [ADDR_WIDTH-1:0]       alloc_addr,
  output logic [ADDR_WIDTH:0]         busy_cnt
);

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]       busy;
  logic                  wen_v;
  vec_t                  raddr_v;

  assign wen_v   = wen && (waddr != ADDR_WIDTH'(ZERO_IDX));
  assign raddr_v = vec_t'(raddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wen_v) begin
      regs_q[waddr] <= wdata;
    end
  end

  ysyx_23060201_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .clr_en    (wen),
    .clr_addr  (waddr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp;
    assign ra  = ADDR_WIDTH'(get_slice(raddr_v, i, ADDR_WIDTH));
    assign byp = (BYPASS != 0) && wen_v && (waddr == ra);
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
      !ren[i] ? '0 : (byp ? wdata : regs_q[ra]);
    assign rbusy[i] = ren[i] && !byp && busy[ra];
  end

  assign stall = |(ren & rbusy);

endmodule
